// File: rtl/phase_sequencer.sv
// phase_sequencer: DDS-style phase accumulator that launches one CORDIC
// rotation per accepted sample tick and holds the returned cos/sin pair.
// Ticks arriving while a conversion is in flight are counted as overruns.
// A conversion that never reports done is aborted after TIMEOUT_CYCLES.
//
// Handshake: the CORDIC link is strobe/done. cordic_strb_o is a single-cycle
// launch pulse; the operands on cordic_X_o/Y_o/Z_o are stable from that
// cycle until the next launch. cordic_done_i is honoured only while
// waiting for a result, and any done pulse at another time is dropped.
// sample_valid_o is a single-cycle pulse with no back-pressure. cos_o and
// sin_o hold their value until the next accepted result.
module phase_sequencer #(
  parameter logic signed [7:0] AMP_INIT       = 8'sd78,
  parameter int unsigned       TIMEOUT_CYCLES = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              sample_tick_i,
  input  logic              phase_clr_i,
  input  logic [15:0]       ftw_i,
  input  logic [7:0]        phase_offset_i,
  output logic              cordic_strb_o,
  output logic signed [7:0] cordic_X_o,
  output logic signed [7:0] cordic_Y_o,
  output logic signed [7:0] cordic_Z_o,
  input  logic              cordic_done_i,
  input  logic signed [7:0] cordic_X_i,
  input  logic signed [7:0] cordic_Y_i,
  output logic signed [7:0] cos_o,
  output logic signed [7:0] sin_o,
  output logic              sample_valid_o,
  output logic              busy_o,
  output logic [7:0]        overrun_cnt_o,
  output logic              timeout_o,
  output logic [1:0]        state_o
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_OUT    = 2'd3;

  localparam int WCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT_CYCLES - 1);

  logic [1:0]        state_q,   state_d;
  logic [15:0]       acc_q,     acc_d;
  logic [WCW-1:0]    wait_q,    wait_d;
  logic signed [7:0] x_q,       x_d;
  logic signed [7:0] y_q,       y_d;
  logic signed [7:0] z_q,       z_d;
  logic signed [7:0] cos_q,     cos_d;
  logic signed [7:0] sin_q,     sin_d;
  logic [7:0]        ovr_q,     ovr_d;
  logic              to_q,      to_d;

  logic              tick_acc;
  logic [7:0]        angle_base;
  logic [7:0]        angle;

  // A clear in the same cycle as a tick means the launch sees a zero accumulator.
  assign tick_acc   = enable_i & sample_tick_i;
  assign angle_base = phase_clr_i ? 8'h00 : acc_q[15:8];
  assign angle      = angle_base + phase_offset_i;

  // Next-state logic: accumulator, overrun counter and the launch/wait/out sequence.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    wait_d  = wait_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    cos_d   = cos_q;
    sin_d   = sin_q;
    ovr_d   = ovr_q;
    to_d    = to_q;

    if (phase_clr_i) begin
      acc_d = 16'h0000;
    end else if (tick_acc) begin
      acc_d = acc_q + ftw_i;
    end

    if (tick_acc && (state_q != S_IDLE) && (ovr_q != 8'hFF)) begin
      ovr_d = ovr_q + 8'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (tick_acc) begin
          state_d = S_LAUNCH;
          z_d     = angle;
          x_d     = AMP_INIT;
          y_d     = 8'sd0;
        end
      end
      S_LAUNCH: begin
        state_d = S_WAIT;
        wait_d  = '0;
      end
      S_WAIT: begin
        if (cordic_done_i) begin
          cos_d   = cordic_X_i;
          sin_d   = cordic_Y_i;
          state_d = S_OUT;
        end else if (wait_q == WAIT_LAST) begin
          to_d    = 1'b1;
          state_d = S_IDLE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_OUT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset clears everything, including the CORDIC operands.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      acc_q   <= 16'h0000;
      wait_q  <= '0;
      x_q     <= 8'sd0;
      y_q     <= 8'sd0;
      z_q     <= 8'sd0;
      cos_q   <= 8'sd0;
      sin_q   <= 8'sd0;
      ovr_q   <= 8'h00;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      wait_q  <= wait_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      cos_q   <= cos_d;
      sin_q   <= sin_d;
      ovr_q   <= ovr_d;
      to_q    <= to_d;
    end
  end

  assign cordic_strb_o  = (state_q == S_LAUNCH);
  assign sample_valid_o = (state_q == S_OUT);
  assign busy_o         = (state_q != S_IDLE);
  assign cordic_X_o     = x_q;
  assign cordic_Y_o     = y_q;
  assign cordic_Z_o     = z_q;
  assign cos_o          = cos_q;
  assign sin_o          = sin_q;
  assign overrun_cnt_o  = ovr_q;
  assign timeout_o      = to_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Bench for phase_sequencer: directed scenarios plus randomized traffic,
// checked every cycle against a timestamp-based reference model.
module tb_phase_sequencer;

  localparam int TMO = 16;
  localparam int BIG = 32'h7fffffff;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b1;
  logic              enable = 1'b0;
  logic              tick = 1'b0;
  logic              clr = 1'b0;
  logic [15:0]       ftw = 16'h0000;
  logic [7:0]        offset = 8'h00;
  logic              cordic_done = 1'b0;
  logic signed [7:0] cordic_xi = 8'sd0;
  logic signed [7:0] cordic_yi = 8'sd0;

  logic              strb;
  logic signed [7:0] x_o, y_o, z_o, cos_o, sin_o;
  logic              valid, busy, to_o;
  logic [7:0]        ovr;
  logic [1:0]        state;

  phase_sequencer dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .enable_i       (enable),
    .sample_tick_i  (tick),
    .phase_clr_i    (clr),
    .ftw_i          (ftw),
    .phase_offset_i (offset),
    .cordic_strb_o  (strb),
    .cordic_X_o     (x_o),
    .cordic_Y_o     (y_o),
    .cordic_Z_o     (z_o),
    .cordic_done_i  (cordic_done),
    .cordic_X_i     (cordic_xi),
    .cordic_Y_i     (cordic_yi),
    .cos_o          (cos_o),
    .sin_o          (sin_o),
    .sample_valid_o (valid),
    .busy_o         (busy),
    .overrun_cnt_o  (ovr),
    .timeout_o      (to_o),
    .state_o        (state)
  );

  // ---------------- check bookkeeping ----------------
  int errors = 0;
  int checks = 0;
  int e = 0;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, e);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, e);
    end
  endtask

  // ---------------- CORDIC stub ----------------
  // mode 0: silent, 1: done stub_delay cycles after strobe, 2: random done, 3: done held high
  int                stub_mode = 0;
  int                stub_delay = 9;
  int                cd = 0;
  logic signed [7:0] stub_x = 8'sh11;
  logic signed [7:0] stub_y = 8'sh22;

  always @(negedge clk) begin
    cordic_done = 1'b0;
    case (stub_mode)
      1: begin
        if (cd > 0) begin
          cd--;
          if (cd == 0) begin
            cordic_done = 1'b1;
            cordic_xi   = stub_x;
            cordic_yi   = stub_y;
          end
        end
        if (strb) cd = stub_delay;
      end
      2: begin
        cordic_done = ($urandom_range(0, 4) == 0);
        cordic_xi   = 8'($urandom);
        cordic_yi   = 8'($urandom);
      end
      3: cordic_done = 1'b1;
      default: cd = 0;
    endcase
  end

  // ---------------- reference model ----------------
  // Timeline view: a launch at edge n strobes after edge n, and its result may
  // be taken at edges n+2 .. n+TMO+1. busy_end is the edge after which the
  // block is idle again; a tick is accepted only at edges strictly later.
  int          t_launch = -1;
  int          busy_end = -1;
  int          valid_edge = -1;
  bit          inflight = 1'b0;
  logic [15:0] m_acc = 16'h0000;
  logic [7:0]  m_x = 8'h00, m_y = 8'h00, m_z = 8'h00;
  logic [7:0]  m_cos = 8'h00, m_sin = 8'h00, m_ovr = 8'h00;
  logic        m_to = 1'b0;
  logic [7:0]  z_seen[$];

  always begin
    @(posedge clk);
    e++;
    if (rst) begin
      t_launch = -1; busy_end = -1; valid_edge = -1; inflight = 1'b0;
      m_acc = 16'h0000; m_x = 8'h00; m_y = 8'h00; m_z = 8'h00;
      m_cos = 8'h00; m_sin = 8'h00; m_ovr = 8'h00; m_to = 1'b0;
    end else begin
      if (inflight && e >= t_launch + 2) begin
        if (cordic_done) begin
          m_cos = cordic_xi; m_sin = cordic_yi;
          valid_edge = e; busy_end = e + 1; inflight = 1'b0;
        end else if (e == t_launch + TMO + 1) begin
          m_to = 1'b1; busy_end = e; inflight = 1'b0;
        end
      end
      if (enable && tick) begin
        if (e > busy_end) begin
          m_z = (clr ? 8'h00 : m_acc[15:8]) + offset;
          m_x = 8'h4E; m_y = 8'h00;
          t_launch = e; busy_end = BIG; inflight = 1'b1;
        end else if (m_ovr != 8'hFF) begin
          m_ovr++;
        end
      end
      if (clr) m_acc = 16'h0000;
      else if (enable && tick) m_acc += ftw;
    end
    #1;
    check1("strb", strb, e == t_launch);
    check1("busy", busy, e < busy_end);
    check1("state_idle", state == 2'd0, !(e < busy_end));
    check1("sample_valid", valid, e == valid_edge);
    check8("cordic_X", x_o, m_x);
    check8("cordic_Y", y_o, m_y);
    check8("cordic_Z", z_o, m_z);
    check8("cos", cos_o, m_cos);
    check8("sin", sin_o, m_sin);
    check8("overrun_cnt", ovr, m_ovr);
    check1("timeout", to_o, m_to);
    if (strb) z_seen.push_back(z_o);
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ticks(input int n, input int gap, input logic with_clr);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tick = 1'b1;
      clr  = with_clr;
      @(negedge clk);
      tick = 1'b0;
      clr  = 1'b0;
      cycles(gap - 2);
    end
  endtask

  task automatic run_random(input int n, input int mode);
    stub_mode = mode;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      enable     = ($urandom_range(0, 7) != 0);
      tick       = ($urandom_range(0, 5) == 0);
      clr        = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 50) == 0) ftw = 16'($urandom);
      if ($urandom_range(0, 30) == 0) offset = 8'($urandom);
      stub_delay = $urandom_range(1, 20);
      rst        = ($urandom_range(0, 399) == 0);
    end
    @(negedge clk);
    rst = 1'b0; tick = 1'b0; clr = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  logic [7:0] sweep_exp[5];
  logic [7:0] clr_exp[3];

  initial begin
    sweep_exp = '{8'h00, 8'h40, 8'h80, 8'hC0, 8'h00};
    clr_exp   = '{8'h10, 8'h10, 8'h22};

    // Reset for two cycles, then every output must read zero.
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
    cycles(1);
    check8("rst_X", x_o, 8'h00);
    check8("rst_Z", z_o, 8'h00);
    check8("rst_cos", cos_o, 8'h00);
    check8("rst_ovr", ovr, 8'h00);
    check1("rst_busy", busy, 1'b0);
    check1("rst_timeout", to_o, 1'b0);
    stub_mode = 3;
    cycles(3);
    stub_mode = 0;
    check1("rst_done_no_valid", valid, 1'b0);
    check8("rst_done_cos", cos_o, 8'h00);

    // Phase sweep: quarter-turn steps.
    enable = 1'b1; ftw = 16'h4000; offset = 8'h00;
    stub_mode = 1; stub_delay = 9; stub_x = 8'sh11; stub_y = 8'sh22;
    z_seen.delete();
    ticks(5, 20, 1'b0);
    check8("sweep_count", 8'(z_seen.size()), 8'd5);
    for (int i = 0; i < 5; i++)
      if (i < z_seen.size()) check8("sweep_Z", z_seen[i], sweep_exp[i]);
    check8("capture_cos", cos_o, 8'h11);
    check8("capture_sin", sin_o, 8'h22);
    check8("launch_X", x_o, 8'h4E);

    // Overrun: tick every 5 cycles against a 9-cycle conversion.
    ftw = 16'h0123;
    ticks(3, 5, 1'b0);
    check8("overrun_first", ovr, 8'd2);
    ticks(460, 5, 1'b0);
    check8("overrun_sat", ovr, 8'hFF);
    cycles(20);

    // Timeout: silent CORDIC.
    stub_mode = 0;
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    cycles(16);
    check1("tmo_before_busy", busy, 1'b1);
    check1("tmo_before_flag", to_o, 1'b0);
    cycles(1);
    check1("tmo_flag", to_o, 1'b1);
    check1("tmo_idle", busy, 1'b0);
    check8("tmo_cos_held", cos_o, 8'h11);
    stub_mode = 1; stub_delay = 3; stub_x = 8'sh5A; stub_y = -8'sh33;
    ticks(1, 20, 1'b0);
    check8("after_tmo_cos", cos_o, 8'h5A);
    check8("after_tmo_sin", sin_o, 8'hCD);

    // Clear priority over the tick increment.
    ftw = 16'h1234; offset = 8'h00;
    ticks(3, 20, 1'b0);
    offset = 8'h10;
    z_seen.delete();
    ticks(1, 20, 1'b1);
    ticks(2, 20, 1'b0);
    check8("clr_count", 8'(z_seen.size()), 8'd3);
    for (int i = 0; i < 3; i++)
      if (i < z_seen.size()) check8("clr_Z", z_seen[i], clr_exp[i]);

    // Reset in the middle of WAIT; a late done must be ignored.
    stub_mode = 0;
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    cycles(5);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    check8("midrst_X", x_o, 8'h00);
    check1("midrst_busy", busy, 1'b0);
    check1("midrst_timeout", to_o, 1'b0);
    stub_mode = 3;
    cycles(4);
    stub_mode = 0;
    check1("midrst_no_valid", valid, 1'b0);
    check8("midrst_cos", cos_o, 8'h00);

    // Randomized traffic.
    run_random(2000, 1);
    run_random(2000, 2);
    cycles(30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
